ccff_chain_programmer: RTL and testbench

//  Driving end of the configuration-chain protocol: accepts the bitstream as parallel

---
 rtl/ccff_chain_programmer_if.sv | 27 ++
 rtl/ccff_chain_programmer.sv | 175 +++++++++++++++++
 tb/tb_ccff_chain_programmer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_programmer_if.sv
// Loader-side bundle of the configuration-chain programmer: session control,
// bitstream word handshake and readback/status signals.
interface ccff_chain_programmer_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              err;

  // SoC-side loader
  modport master (
    output start, cfg_data, cfg_valid,
    input  cfg_ready, rd_data, rd_valid, busy, done, err
  );

  // Programmer
  modport slave (
    input  start, cfg_data, cfg_valid,
    output cfg_ready, rd_data, rd_valid, busy, done, err
  );
endinterface

// File: rtl/ccff_chain_programmer.sv
// Driving end of the FPGA configuration chain: serialises bitstream words onto
// ccff_head LSB first, collects ccff_tail into readback words, and holds the
// fabric in configuration mode (config_enable high, IO isolated) while shifting.
module ccff_chain_programmer #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                     prog_clk,
  input  logic                     pReset,
  ccff_chain_programmer_if.slave   bus,
  output logic                     ccff_head,
  output logic                     ccff_shift_en,
  input  logic                     ccff_tail,
  output logic                     config_enable,
  output logic                     IO_ISOL_N
);

  localparam int LW = $clog2(CHAIN_LEN + 1);
  localparam int CW = $clog2(WORD_W + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [LW-1:0] LP_LEN = LW'(CHAIN_LEN);

  logic [1:0]        r_state;
  logic              r_err;
  logic [TW-1:0]     r_stall_cnt;

  logic [WORD_W-1:0] r_buf;
  logic [CW-1:0]     r_buf_cnt;
  logic              r_buf_full;
  logic [WORD_W-1:0] r_shreg;
  logic [CW-1:0]     r_sh_cnt;
  logic [LW-1:0]     r_ld_bits;
  logic [LW-1:0]     r_bit_cnt;

  logic [WORD_W-1:0] r_rd_shreg;
  logic [CW-1:0]     r_rd_cnt;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic              w_in_shift;
  logic              w_start_sess;
  logic              w_shift_en;
  logic              w_cfg_ready;
  logic              w_accept;
  logic              w_load;
  logic              w_last_bit;
  logic              w_timeout;
  logic [LW-1:0]     w_remain;
  logic [CW-1:0]     w_acc_bits;
  logic [WORD_W-1:0] w_rd_word;

  assign w_in_shift   = (r_state == ST_SHIFT);
  assign w_start_sess = (r_state == ST_IDLE) & bus.start;
  assign w_shift_en   = w_in_shift & (r_sh_cnt != '0);
  assign w_cfg_ready  = w_in_shift & ~r_buf_full & (r_ld_bits < LP_LEN);
  assign w_accept     = bus.cfg_valid & w_cfg_ready;
  // Reload on an empty shifter, or on the last bit of the current word so
  // back-to-back words stream without a bubble.
  assign w_load       = w_in_shift & r_buf_full &
                        ((r_sh_cnt == '0) | (w_shift_en & (r_sh_cnt == CW'(1))));
  assign w_last_bit   = w_shift_en & (r_bit_cnt == LW'(CHAIN_LEN - 1));
  assign w_timeout    = w_in_shift & ~w_shift_en & (r_stall_cnt == TW'(TIMEOUT - 1));
  assign w_remain     = LP_LEN - r_ld_bits;
  assign w_rd_word    = r_rd_shreg | (WORD_W'(ccff_tail) << r_rd_cnt);

  // Bits taken from the next word: a full word, or only what the chain still needs
  always_comb begin
    w_acc_bits = CW'(WORD_W);
    if (int'(w_remain) < WORD_W) w_acc_bits = CW'(w_remain);
  end

  assign ccff_shift_en = w_shift_en;
  assign ccff_head     = w_shift_en & r_shreg[0];
  assign config_enable = w_in_shift;
  assign IO_ISOL_N     = ~w_in_shift;
  assign bus.cfg_ready = w_cfg_ready;
  assign bus.busy      = w_in_shift;
  assign bus.done      = (r_state == ST_DONE);
  assign bus.err       = r_err;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;

  // Session FSM with stall watchdog; DONE lasts a single cycle
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state     <= ST_IDLE;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_stall_cnt <= '0;
          if (bus.start) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_last_bit) begin
            r_state     <= ST_DONE;
            r_stall_cnt <= '0;
          end else if (w_timeout) begin
            r_state     <= ST_IDLE;
            r_err       <= 1'b1;
            r_stall_cnt <= '0;
          end else if (w_shift_en) begin
            r_stall_cnt <= '0;
          end else begin
            r_stall_cnt <= r_stall_cnt + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Word buffer and head-side shifter; a new session or an abort discards everything
  always_ff @(posedge prog_clk) begin
    if (pReset | w_start_sess | w_timeout) begin
      r_buf      <= '0;
      r_buf_cnt  <= '0;
      r_buf_full <= 1'b0;
      r_shreg    <= '0;
      r_sh_cnt   <= '0;
      r_ld_bits  <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_buf     <= bus.cfg_data;
        r_buf_cnt <= w_acc_bits;
        r_ld_bits <= r_ld_bits + LW'(w_acc_bits);
      end
      r_buf_full <= (r_buf_full & ~w_load) | w_accept;
      if (w_load) begin
        r_shreg  <= r_buf;
        r_sh_cnt <= r_buf_cnt;
      end else if (w_shift_en) begin
        r_shreg  <= r_shreg >> 1;
        r_sh_cnt <= r_sh_cnt - CW'(1);
      end
      if (w_shift_en) r_bit_cnt <= r_bit_cnt + LW'(1);
    end
  end

  // Tail capture: emit a word every WORD_W samples or on the final chain bit
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_rd_shreg <= '0;
      r_rd_cnt   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_start_sess | w_timeout) begin
        r_rd_shreg <= '0;
        r_rd_cnt   <= '0;
      end else if (w_shift_en) begin
        if ((r_rd_cnt == CW'(WORD_W - 1)) | w_last_bit) begin
          r_rd_data  <= w_rd_word;
          r_rd_valid <= 1'b1;
          r_rd_shreg <= '0;
          r_rd_cnt   <= '0;
        end else begin
          r_rd_shreg <= w_rd_word;
          r_rd_cnt   <= r_rd_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Bench for ccff_chain_programmer (CHAIN_LEN=20, WORD_W=8, TIMEOUT=16) with a
// 20-flop chain model on head/tail and a queue-based scoreboard.
module tb_ccff_chain_programmer;

  logic prog_clk = 1'b0;
  logic pReset;
  logic ccff_head, ccff_shift_en, ccff_tail, config_enable, IO_ISOL_N;

  ccff_chain_programmer_if #(.WORD_W(8)) bus ();

  ccff_chain_programmer #(.CHAIN_LEN(20), .WORD_W(8), .TIMEOUT(16)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .bus           (bus),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .config_enable (config_enable),
    .IO_ISOL_N     (IO_ISOL_N)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: head enters flop 0, tail is flop 19
  logic [19:0] chain;
  logic        chain_clr;
  always @(posedge prog_clk) begin
    if (chain_clr)          chain <= '0;
    else if (ccff_shift_en) chain <= {chain[18:0], ccff_head};
  end
  assign ccff_tail = chain[19];

  // Expected head sequence for words 0xA5, 0x3C, 0x0F (low nibble only), LSB first
  bit head_tab [20] = '{1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1};

  bit         head_q [$];
  logic [7:0] rd_q   [$];

  int n_chk = 0, n_pass = 0;
  int n_shift, n_gap, n_done, n_err, n_busy, n_rd;
  bit prev_shift = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT presents a head bit or readback word
  initial begin
    forever begin
      @(negedge prog_clk);
      if (ccff_shift_en) begin
        n_shift++;
        if (head_q.size() == 0) check("head_unexpected", 32'(ccff_head), 32'hDEAD);
        else check("head_bit", 32'(ccff_head), 32'(head_q.pop_front()));
      end
      if (bus.busy && !ccff_shift_en && n_shift > 0) n_gap++;
      if (bus.busy) n_busy++;
      if (bus.rd_valid) begin
        n_rd++;
        if (rd_q.size() == 0) check("rd_unexpected", 32'(bus.rd_data), 32'hDEAD);
        else check("rd_data", 32'(bus.rd_data), 32'(rd_q.pop_front()));
      end
      if (bus.done) begin
        n_done++;
        check("done_after_last_shift", 32'(prev_shift), 32'd1);
        check("rd_valid_with_done", 32'(bus.rd_valid), 32'd1);
      end
      if (bus.err) n_err++;
      prev_shift = ccff_shift_en;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  task automatic zero_counts();
    n_shift = 0; n_gap = 0; n_done = 0; n_err = 0; n_busy = 0; n_rd = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd0);
    check({tag, "_shift_en"},  32'(ccff_shift_en), 32'd0);
    check({tag, "_head"},      32'(ccff_head), 32'd0);
    check({tag, "_cfg_en"},    32'(config_enable), 32'd0);
    check({tag, "_io_isol_n"}, 32'(IO_ISOL_N), 32'd1);
    check({tag, "_rd_valid"},  32'(bus.rd_valid), 32'd0);
    check({tag, "_rd_data"},   32'(bus.rd_data), 32'd0);
    check({tag, "_busy"},      32'(bus.busy), 32'd0);
    check({tag, "_done"},      32'(bus.done), 32'd0);
    check({tag, "_err"},       32'(bus.err), 32'd0);
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge
  task automatic send(input logic [7:0] w);
    int t = 0;
    bus.cfg_data  = w;
    bus.cfg_valid = 1'b1;
    while (!bus.cfg_ready && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    if (t >= 100) check("cfg_ready_wait", 32'(bus.cfg_ready), 32'd1);
    @(posedge prog_clk);
    #1 bus.cfg_valid = 1'b0;
    @(negedge prog_clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge prog_clk);
    bus.start = 1'b0;
  endtask

  task automatic run_session(input string tag, input int hold, input bit poke,
                             input logic [7:0] r0, input logic [7:0] r1,
                             input logic [7:0] r2, input int exp_gap);
    int t = 0;
    #1 zero_counts();
    for (int i = 0; i < 20; i++) head_q.push_back(head_tab[i]);
    rd_q.push_back(r0); rd_q.push_back(r1); rd_q.push_back(r2);
    pulse_start();
    send(8'hA5);
    if (poke) pulse_start();
    repeat (hold) @(negedge prog_clk);
    send(8'h3C);
    send(8'hFF & 8'h0F);
    while (!bus.done && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    if (poke) pulse_start();
    repeat (4) @(negedge prog_clk);
    #1;
    check({tag, "_n_done"},  32'(n_done), 32'd1);
    check({tag, "_n_err"},   32'(n_err), 32'd0);
    check({tag, "_n_shift"}, 32'(n_shift), 32'd20);
    check({tag, "_n_gap"},   32'(n_gap), 32'(exp_gap));
    check({tag, "_n_rd"},    32'(n_rd), 32'd3);
    check({tag, "_head_q"},  32'(head_q.size()), 32'd0);
    check({tag, "_idle"},    32'(bus.busy), 32'd0);
    check({tag, "_io_isol"}, 32'(IO_ISOL_N), 32'd1);
  endtask

  initial begin
    int t;
    pReset = 1'b1; chain_clr = 1'b1;
    bus.start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = '0;
    repeat (3) @(negedge prog_clk);
    check_reset("por");
    pReset = 1'b0; chain_clr = 1'b0;
    @(negedge prog_clk);

    // Chain preloaded with zeros: readback all zero
    run_session("s1", 0, 1'b0, 8'h00, 8'h00, 8'h00, 0);
    // Chain now holds session 1's bitstream; last word zero-padded to 0x0F
    run_session("s2", 0, 1'b0, 8'hA5, 8'h3C, 8'h0F, 0);
    // Ready returns one cycle after word 1 is accepted and word 1 drains 8 cycles
    // after that, so holding word 2 back 12 cycles idles the chain for 5 cycles
    run_session("s3", 12, 1'b0, 8'hA5, 8'h3C, 8'h0F, 5);

    // No data after start: watchdog abort after 16 SHIFT cycles
    #1 zero_counts();
    pulse_start();
    t = 0;
    while (!bus.err && t < 50) begin
      @(negedge prog_clk);
      t++;
    end
    #1;
    check("s4_err_seen",  32'(bus.err), 32'd1);
    check("s4_shift_cyc", 32'(n_busy), 32'd16);
    check("s4_io_isol",   32'(IO_ISOL_N), 32'd1);
    check("s4_cfg_en",    32'(config_enable), 32'd0);
    check("s4_busy",      32'(bus.busy), 32'd0);
    repeat (4) @(negedge prog_clk);
    #1;
    check("s4_n_err",  32'(n_err), 32'd1);
    check("s4_n_done", 32'(n_done), 32'd0);
    check("s4_n_rd",   32'(n_rd), 32'd0);
    check("s4_ready",  32'(bus.cfg_ready), 32'd0);

    // Reset in the middle of a session after 10 shifts
    zero_counts();
    for (int i = 0; i < 10; i++) head_q.push_back(head_tab[i]);
    rd_q.push_back(8'hA5);
    pulse_start();
    send(8'hA5);
    send(8'h3C);
    t = 0;
    while (n_shift < 10 && t < 100) begin
      @(negedge prog_clk);
      #1;
      t++;
    end
    check("s5_reached_10", 32'(n_shift), 32'd10);
    pReset = 1'b1;
    @(posedge prog_clk);
    #1 pReset = 1'b0;
    @(negedge prog_clk);
    check_reset("s5");
    #1;
    check("s5_n_done", 32'(n_done), 32'd0);
    check("s5_n_err",  32'(n_err), 32'd0);
    check("s5_rd_q",   32'(rd_q.size()), 32'd0);
    check("s5_head_q", 32'(head_q.size()), 32'd0);
    chain_clr = 1'b1;
    @(negedge prog_clk);
    chain_clr = 1'b0;
    run_session("s5b", 0, 1'b0, 8'h00, 8'h00, 8'h00, 0);

    // start pulses during SHIFT and in DONE are ignored
    run_session("s6", 0, 1'b1, 8'hA5, 8'h3C, 8'h0F, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
